// File: rtl/nasbus_buf_ctl.sv
// rtl/nasbus_buf_ctl.sv - NAS-BUS data transceiver direction/disable sequencer
//
// Decodes Z80 bus cycles aimed at the NAS-BUS, steers the octal transceiver
// between the CPU data bus (port A) and the NAS-BUS (port B), inserts a
// disabled turnaround on every direction reversal and stretches the CPU cycle
// with programmed wait states plus the NAS-BUS wait request.
//
// Parameters:
//   TURN         disabled cycles on a direction reversal (1..15)
//   WAIT_STATES  minimum wait cycles per external access (0..15)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   mreq_n       Z80 MREQ, active low
//   iorq_n       Z80 IORQ, active low
//   rd_n         Z80 RD, active low
//   wr_n         Z80 WR, active low
//   m1_n         Z80 M1, active low
//   ext_sel_n    0 = current access targets the NAS-BUS
//   nas_wait_n   NAS-BUS wait request, active low
//   buf_dir      transceiver direction, 1 = A->B (write), 0 = B->A (read)
//   buf_cd       transceiver disable, 1 = all outputs off
//   cpu_wait_n   Z80 WAIT, active low
//   err          sticky flag: read and write strobed together

module nasbus_buf_ctl #(
  parameter int TURN        = 1,
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mreq_n,
  input  logic iorq_n,
  input  logic rd_n,
  input  logic wr_n,
  input  logic m1_n,
  input  logic ext_sel_n,
  input  logic nas_wait_n,
  output logic buf_dir,
  output logic buf_cd,
  output logic cpu_wait_n,
  output logic err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TURN   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  // tcnt counts down the remaining turnaround cycles, so a reversal spends
  // exactly TURN edges in S_TURN before the transceiver is enabled.
  localparam logic [3:0] TURN_LOAD = 4'(TURN - 1);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_t     state;
  state_t     state_nx;
  logic [3:0] tcnt;
  logic [3:0] tcnt_nx;
  logic [3:0] wcnt;
  logic [3:0] wcnt_nx;
  logic       buf_dir_nx;
  logic       buf_cd_nx;
  logic       cpu_wait_n_nx;
  logic       err_nx;

  logic       bus_cyc;
  logic       rd_req;
  logic       wr_req;
  logic       both_req;
  logic       req;
  logic       need_dir;
  logic       dir_change;

  // Cycle decode. An interrupt acknowledge reads the vector from the bus,
  // so it counts as a read. Read and write together is not a real Z80
  // cycle; it is flagged and otherwise treated as no request at all.
  always_comb begin
    bus_cyc    = !mreq_n || !iorq_n;
    rd_req     = !ext_sel_n && ((bus_cyc && !rd_n) || (!m1_n && !iorq_n));
    wr_req     = !ext_sel_n && bus_cyc && !wr_n;
    both_req   = rd_req && wr_req;
    req        = (rd_req || wr_req) && !both_req;
    need_dir   = wr_req;
    dir_change = req && (need_dir != buf_dir);
  end

  // State register; every output is a flop so the transceiver pins and
  // the Z80 WAIT line are glitch free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tcnt       <= 4'd0;
      wcnt       <= 4'd0;
      buf_dir    <= 1'b1;
      buf_cd     <= 1'b1;
      cpu_wait_n <= 1'b1;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      tcnt       <= tcnt_nx;
      wcnt       <= wcnt_nx;
      buf_dir    <= buf_dir_nx;
      buf_cd     <= buf_cd_nx;
      cpu_wait_n <= cpu_wait_n_nx;
      err        <= err_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nx = dir_change ? S_TURN : S_ACTIVE;
        end
      end
      S_TURN: begin
        // A direction flip while still turning around simply restarts the
        // turnaround toward the new direction; the transceiver stays off.
        if (!req) begin
          state_nx = S_IDLE;
        end else if (dir_change) begin
          state_nx = S_TURN;
        end else if (tcnt == 4'd0) begin
          state_nx = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (!req) begin
          state_nx = S_IDLE;
        end else if (dir_change) begin
          state_nx = S_TURN;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Output and counter logic: values the flops take on the coming edge.
  always_comb begin
    buf_dir_nx    = buf_dir;
    tcnt_nx       = tcnt;
    wcnt_nx       = wcnt;
    err_nx        = err || both_req;
    buf_cd_nx     = 1'b1;
    cpu_wait_n_nx = 1'b1;

    // buf_dir only moves on an edge that starts (or restarts) a turnaround,
    // and buf_cd is 1 after every such edge, so the transceiver is never
    // enabled while its direction changes.
    if (state_nx == S_TURN && dir_change) begin
      buf_dir_nx = need_dir;
      tcnt_nx    = TURN_LOAD;
    end else if (state == S_TURN && state_nx == S_TURN && tcnt != 4'd0) begin
      tcnt_nx = tcnt - 4'd1;
    end

    // Wait-state counter is loaded on ACTIVE entry and runs down to zero.
    if (state_nx == S_ACTIVE && state != S_ACTIVE) begin
      wcnt_nx = WAIT_LOAD;
    end else if (state == S_ACTIVE && state_nx == S_ACTIVE && wcnt != 4'd0) begin
      wcnt_nx = wcnt - 4'd1;
    end

    case (state_nx)
      S_TURN: begin
        buf_cd_nx     = 1'b1;
        cpu_wait_n_nx = 1'b0;
      end
      S_ACTIVE: begin
        buf_cd_nx     = 1'b0;
        cpu_wait_n_nx = (wcnt_nx == 4'd0) && nas_wait_n;
      end
      default: begin
        buf_cd_nx     = 1'b1;
        cpu_wait_n_nx = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_nasbus_buf_ctl.sv
// tb/tb_nasbus_buf_ctl.sv - model-checked bench for nasbus_buf_ctl
module tb_nasbus_buf_ctl;

  localparam int NI = 3;

  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic mreq_n     = 1'b1;
  logic iorq_n     = 1'b1;
  logic rd_n       = 1'b1;
  logic wr_n       = 1'b1;
  logic m1_n       = 1'b1;
  logic ext_sel_n  = 1'b1;
  logic nas_wait_n = 1'b1;

  logic [NI-1:0] dir_o;
  logic [NI-1:0] cd_o;
  logic [NI-1:0] wait_o;
  logic [NI-1:0] err_o;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model: per instance, a phase (0 idle, 1 turnaround, 2 enabled),
  // the number of edges spent in that phase, the retained direction and the
  // sticky error, plus the expected registered outputs.
  int   m_mode [NI];
  int   m_age  [NI];
  logic e_dir  [NI];
  logic e_cd   [NI];
  logic e_wait [NI];
  logic e_err  [NI];

  always #5 clk = ~clk;

  nasbus_buf_ctl #(.TURN(1), .WAIT_STATES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n),
    .wr_n(wr_n), .m1_n(m1_n), .ext_sel_n(ext_sel_n), .nas_wait_n(nas_wait_n),
    .buf_dir(dir_o[0]), .buf_cd(cd_o[0]), .cpu_wait_n(wait_o[0]), .err(err_o[0])
  );

  nasbus_buf_ctl #(.TURN(2), .WAIT_STATES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n),
    .wr_n(wr_n), .m1_n(m1_n), .ext_sel_n(ext_sel_n), .nas_wait_n(nas_wait_n),
    .buf_dir(dir_o[1]), .buf_cd(cd_o[1]), .cpu_wait_n(wait_o[1]), .err(err_o[1])
  );

  nasbus_buf_ctl #(.TURN(3), .WAIT_STATES(0)) u_c (
    .clk(clk), .rst_n(rst_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n),
    .wr_n(wr_n), .m1_n(m1_n), .ext_sel_n(ext_sel_n), .nas_wait_n(nas_wait_n),
    .buf_dir(dir_o[2]), .buf_cd(cd_o[2]), .cpu_wait_n(wait_o[2]), .err(err_o[2])
  );

  function automatic int turn_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 3;
  endfunction

  function automatic int ws_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 0;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_mode[i] = 0;
      m_age[i]  = 0;
      e_dir[i]  = 1'b1;
      e_cd[i]   = 1'b1;
      e_wait[i] = 1'b1;
      e_err[i]  = 1'b0;
    end
  endtask

  task automatic model_step();
    logic is_rd;
    logic is_wr;
    logic ok;
    logic want;
    if (!rst_n) begin
      model_reset();
      return;
    end
    is_rd = !ext_sel_n && (((!mreq_n || !iorq_n) && !rd_n) || (!m1_n && !iorq_n));
    is_wr = !ext_sel_n && (!mreq_n || !iorq_n) && !wr_n;
    ok    = is_rd ^ is_wr;
    want  = is_wr;
    for (int i = 0; i < NI; i++) begin
      if (is_rd && is_wr) e_err[i] = 1'b1;
      if (!ok) begin
        m_mode[i] = 0;
      end else if (want != e_dir[i]) begin
        m_mode[i] = 1;
        m_age[i]  = 0;
        e_dir[i]  = want;
      end else if (m_mode[i] == 0) begin
        m_mode[i] = 2;
        m_age[i]  = 0;
      end else if (m_mode[i] == 1 && m_age[i] + 1 >= turn_of(i)) begin
        m_mode[i] = 2;
        m_age[i]  = 0;
      end else begin
        m_age[i]++;
      end
      e_cd[i] = (m_mode[i] != 2);
      if (m_mode[i] == 0)      e_wait[i] = 1'b1;
      else if (m_mode[i] == 1) e_wait[i] = 1'b0;
      else                     e_wait[i] = (m_age[i] >= ws_of(i)) ? nas_wait_n : 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic set_bus(input int kind);
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    ext_sel_n = 1'b0;
    case (kind)
      0: ext_sel_n = 1'b1;
      1: begin mreq_n = 1'b0; rd_n = 1'b0; end
      2: begin mreq_n = 1'b0; wr_n = 1'b0; end
      3: begin iorq_n = 1'b0; rd_n = 1'b0; end
      4: begin iorq_n = 1'b0; wr_n = 1'b0; end
      5: begin m1_n = 1'b0; iorq_n = 1'b0; end
      6: begin mreq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; end
      7: begin mreq_n = 1'b0; rd_n = 1'b0; ext_sel_n = 1'b1; end
      8: begin mreq_n = 1'b0; wr_n = 1'b0; ext_sel_n = 1'b1; end
      default: ;
    endcase
  endtask

  // Compare process: DUT against the model on every falling edge, plus the
  // rule that the direction never moves while the transceiver stays enabled.
  initial begin
    logic prev_cd  [NI];
    logic prev_dir [NI];
    bit   have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int i = 0; i < NI; i++) begin
          check($sformatf("buf_dir[%0d]", i), dir_o[i], e_dir[i]);
          check($sformatf("buf_cd[%0d]", i), cd_o[i], e_cd[i]);
          check($sformatf("cpu_wait_n[%0d]", i), wait_o[i], e_wait[i]);
          check($sformatf("err[%0d]", i), err_o[i], e_err[i]);
          if (have_prev && prev_cd[i] == 1'b0 && cd_o[i] == 1'b0)
            check($sformatf("dir_stable_enabled[%0d]", i), dir_o[i], prev_dir[i]);
          prev_cd[i]  = cd_o[i];
          prev_dir[i] = dir_o[i];
        end
        have_prev = 1'b1;
      end
    end
  end

  initial begin
    int low_cnt;
    int cd_hi;
    int hold;
    int kind;

    model_reset();
    rst_n = 1'b0;
    set_bus(0);
    tick();
    tick();
    cmp_en = 1'b1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst buf_dir[%0d]", i), dir_o[i], 1'b1);
      check($sformatf("rst buf_cd[%0d]", i), cd_o[i], 1'b1);
      check($sformatf("rst cpu_wait_n[%0d]", i), wait_o[i], 1'b1);
      check($sformatf("rst err[%0d]", i), err_o[i], 1'b0);
    end
    rst_n = 1'b1;
    tick();

    // Write, same direction as reset: enabled after one edge.
    set_bus(2);
    tick();
    check("wr a buf_cd", cd_o[0], 1'b0);
    check("wr a buf_dir", dir_o[0], 1'b1);
    check("wr a cpu_wait_n", wait_o[0], 1'b0);
    check("wr model a cpu_wait_n", e_wait[0], 1'b0);
    check("wr c cpu_wait_n", wait_o[2], 1'b1);
    tick();
    check("wr a wait released", wait_o[0], 1'b1);
    check("wr b still waiting", wait_o[1], 1'b0);
    check("wr model b wait", e_wait[1], 1'b0);
    set_bus(9);
    tick();
    check("drop a buf_cd", cd_o[0], 1'b1);
    check("drop a cpu_wait_n", wait_o[0], 1'b1);

    // Read after write with NAS-BUS stall after the wait states expire.
    set_bus(1);
    low_cnt = 0;
    cd_hi   = 0;
    for (int k = 0; k < 10; k++) begin
      nas_wait_n = !(k >= 4 && k <= 6);
      tick();
      if (wait_o[1] == 1'b0) low_cnt++;
      if (cd_o[1] == 1'b1) cd_hi++;
      if (k == 0) begin
        check("rd b buf_dir", dir_o[1], 1'b0);
        check("rd b buf_cd", cd_o[1], 1'b1);
      end
    end
    nas_wait_n = 1'b1;
    check("rd b wait low cycles==7", (low_cnt == 7), 1'b1);
    check("rd b disabled cycles==2", (cd_hi == 2), 1'b1);

    // Interrupt acknowledge after a write reverses toward the CPU.
    set_bus(2); tick(); tick();
    set_bus(9); tick();
    set_bus(5); tick(); tick(); tick();
    check("intack a buf_dir", dir_o[0], 1'b0);
    check("intack a buf_cd", cd_o[0], 1'b0);
    check("intack c buf_dir", dir_o[2], 1'b0);
    check("intack c turning", cd_o[2], 1'b1);
    check("intack model c cd", e_cd[2], 1'b1);

    // Access not aimed at the NAS-BUS.
    set_bus(9); tick();
    set_bus(7); tick(); tick(); tick();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("local buf_cd[%0d]", i), cd_o[i], 1'b1);
      check($sformatf("local cpu_wait_n[%0d]", i), wait_o[i], 1'b1);
    end

    // Read and write together: no enable, sticky error.
    set_bus(6); tick();
    check("illegal a buf_cd", cd_o[0], 1'b1);
    check("illegal a err", err_o[0], 1'b1);
    set_bus(9); tick(); tick();
    for (int i = 0; i < NI; i++)
      check($sformatf("err sticky[%0d]", i), err_o[i], 1'b1);

    // Asynchronous reset in the middle of an enabled read.
    set_bus(1); tick(); tick(); tick(); tick();
    check("pre-rst a buf_cd", cd_o[0], 1'b0);
    check("pre-rst a buf_dir", dir_o[0], 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async rst a buf_cd", cd_o[0], 1'b1);
    check("async rst a buf_dir", dir_o[0], 1'b1);
    check("async rst a cpu_wait_n", wait_o[0], 1'b1);
    check("async rst a err", err_o[0], 1'b0);
    check("async rst b buf_cd", cd_o[1], 1'b1);
    tick();
    rst_n = 1'b1;
    set_bus(9);
    tick();

    // Randomized traffic against the model.
    hold = 0;
    kind = 0;
    for (int n = 0; n < 4000; n++) begin
      if (hold == 0) begin
        kind = $urandom_range(0, 9);
        if ($urandom_range(0, 15) == 0) kind = 6;
        hold = $urandom_range(1, 8);
      end
      hold--;
      set_bus(kind);
      nas_wait_n = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      tick();
    end

    set_bus(9);
    rst_n = 1'b1;
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
